// File: rtl/iso7816_act_seq.sv
// ---------------------------------------------------------------------------
// iso7816_act_seq
// Card contact activation / warm-reset / deactivation sequencer. All dwell
// times are counted in card-clock ticks (card_tick) from the clock divider.
//
// Ports
//   clk, rst_n        system clock, asynchronous active-low reset
//   card_tick         one-cycle strobe per card clock period
//   cmd_activate      start cold activation (OFF only)
//   cmd_warm          warm reset (ACTIVE only)
//   cmd_deactivate    start deactivation (PWR_UP, CLK_ON, ATR_WAIT, ACTIVE)
//   rx_stb            character received strobe from the character core
//   cfg_t_*           dwell times in ticks minus 1, sampled on state entry
//   card_vcc_en, card_clk_en, card_rst_n   card contact controls
//   io_ena            enables the character core's TX/RX
//   state, busy, active, evt_atr, atr_timeout   status
//
// state     | meaning
// ----------+-------------------------------------------------------------
// OFF       | card unpowered, waiting for cmd_activate
// PWR_UP    | VCC on, waiting for supply to settle before starting CLK
// CLK_ON    | CLK running, RST held low (cold or warm reset)
// ATR_WAIT  | RST released, waiting for first ATR character
// ACTIVE    | card answered, normal operation
// DEACT_RST | RST low and IO disabled, first deactivation step
// DEACT_CLK | CLK stopped
// DEACT_PWR | VCC off, waiting before returning to OFF
// ---------------------------------------------------------------------------
module iso7816_act_seq #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         card_tick,
   input  logic         cmd_activate,
   input  logic         cmd_warm,
   input  logic         cmd_deactivate,
   input  logic         rx_stb,
   input  logic [W-1:0] cfg_t_pwr,
   input  logic [W-1:0] cfg_t_rst,
   input  logic [W-1:0] cfg_t_atr,
   input  logic [W-1:0] cfg_t_off,
   output logic         card_vcc_en,
   output logic         card_clk_en,
   output logic         card_rst_n,
   output logic         io_ena,
   output logic [2:0]   state,
   output logic         busy,
   output logic         active,
   output logic         evt_atr,
   output logic         atr_timeout
);

   typedef enum logic [2:0] {
      ST_OFF       = 3'd0,
      ST_PWR_UP    = 3'd1,
      ST_CLK_ON    = 3'd2,
      ST_ATR_WAIT  = 3'd3,
      ST_ACTIVE    = 3'd4,
      ST_DEACT_RST = 3'd5,
      ST_DEACT_CLK = 3'd6,
      ST_DEACT_PWR = 3'd7
   } state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   cnt_q, cnt_d;
   logic           vcc_q, vcc_d;
   logic           clk_en_q, clk_en_d;
   logic           rst_n_q, rst_n_d;
   logic           io_q, io_d;
   logic           busy_q, busy_d;
   logic           active_q, active_d;
   logic           evt_q, evt_d;
   logic           to_q, to_d;
   logic           expire;
   logic           deact_ok;

   assign expire = card_tick && (cnt_q == '0);

   always_comb begin
      deact_ok = 1'b0;
      case (state_q)
         ST_PWR_UP, ST_CLK_ON, ST_ATR_WAIT, ST_ACTIVE: deact_ok = 1'b1;
         default:                                      deact_ok = 1'b0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      vcc_d    = vcc_q;
      clk_en_d = clk_en_q;
      rst_n_d  = rst_n_q;
      io_d     = io_q;
      evt_d    = 1'b0;
      to_d     = to_q;

      if (cmd_deactivate && deact_ok) begin
         // VCC/CLK keep their current level so an abort from PWR_UP never
         // starts the card clock.
         state_d = ST_DEACT_RST;
         rst_n_d = 1'b0;
         io_d    = 1'b0;
         cnt_d   = cfg_t_off;
      end else begin
         case (state_q)
            ST_OFF: begin
               if (cmd_activate) begin
                  state_d = ST_PWR_UP;
                  vcc_d   = 1'b1;
                  cnt_d   = cfg_t_pwr;
               end
            end
            ST_PWR_UP: begin
               if (expire) begin
                  state_d  = ST_CLK_ON;
                  clk_en_d = 1'b1;
                  io_d     = 1'b1;
                  rst_n_d  = 1'b0;
                  cnt_d    = cfg_t_rst;
               end else if (card_tick) begin
                  cnt_d = cnt_q - W'(1);
               end
            end
            ST_CLK_ON: begin
               if (expire) begin
                  state_d = ST_ATR_WAIT;
                  rst_n_d = 1'b1;
                  to_d    = 1'b0;
                  cnt_d   = cfg_t_atr;
               end else if (card_tick) begin
                  cnt_d = cnt_q - W'(1);
               end
            end
            ST_ATR_WAIT: begin
               // A character on the expiring tick still counts as an answer.
               if (rx_stb) begin
                  state_d = ST_ACTIVE;
                  evt_d   = 1'b1;
               end else if (expire) begin
                  state_d = ST_DEACT_RST;
                  rst_n_d = 1'b0;
                  io_d    = 1'b0;
                  to_d    = 1'b1;
                  cnt_d   = cfg_t_off;
               end else if (card_tick) begin
                  cnt_d = cnt_q - W'(1);
               end
            end
            ST_ACTIVE: begin
               if (cmd_warm) begin
                  state_d = ST_CLK_ON;
                  rst_n_d = 1'b0;
                  cnt_d   = cfg_t_rst;
               end
            end
            ST_DEACT_RST: begin
               if (expire) begin
                  state_d  = ST_DEACT_CLK;
                  clk_en_d = 1'b0;
                  cnt_d    = cfg_t_off;
               end else if (card_tick) begin
                  cnt_d = cnt_q - W'(1);
               end
            end
            ST_DEACT_CLK: begin
               if (expire) begin
                  state_d = ST_DEACT_PWR;
                  vcc_d   = 1'b0;
                  cnt_d   = cfg_t_off;
               end else if (card_tick) begin
                  cnt_d = cnt_q - W'(1);
               end
            end
            ST_DEACT_PWR: begin
               if (expire) begin
                  state_d = ST_OFF;
               end else if (card_tick) begin
                  cnt_d = cnt_q - W'(1);
               end
            end
            default: begin
               state_d = ST_OFF;
            end
         endcase
      end

      busy_d   = !((state_d == ST_OFF) || (state_d == ST_ACTIVE));
      active_d = (state_d == ST_ACTIVE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_OFF;
         cnt_q    <= '0;
         vcc_q    <= 1'b0;
         clk_en_q <= 1'b0;
         rst_n_q  <= 1'b0;
         io_q     <= 1'b0;
         busy_q   <= 1'b0;
         active_q <= 1'b0;
         evt_q    <= 1'b0;
         to_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         vcc_q    <= vcc_d;
         clk_en_q <= clk_en_d;
         rst_n_q  <= rst_n_d;
         io_q     <= io_d;
         busy_q   <= busy_d;
         active_q <= active_d;
         evt_q    <= evt_d;
         to_q     <= to_d;
      end
   end

   assign state       = state_q;
   assign card_vcc_en = vcc_q;
   assign card_clk_en = clk_en_q;
   assign card_rst_n  = rst_n_q;
   assign io_ena      = io_q;
   assign busy        = busy_q;
   assign active      = active_q;
   assign evt_atr     = evt_q;
   assign atr_timeout = to_q;

endmodule

// File: doc/iso7816_act_seq.md
# iso7816_act_seq

Card activation/deactivation sequencer for the ISO7816 interface. Drives card VCC, CLK and RST in the contact activation, warm-reset and deactivation order. Gates the character core's TX/RX enables and times the ATR window. It sits beside `iso7816_core`/`iso7816_brg_sync`, and all of its timing is counted in card-clock ticks from the clock divider.

## Interface
- `W`, 16: width of all timing counters and config values.

- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous, active-low reset
- `card_tick`  in  1  one-cycle strobe per card clock period; free-running, independent of `card_clk_en`
- `cmd_activate`  in  1  pulse; start cold activation; honoured only in OFF
- `cmd_warm`  in  1  pulse; warm reset; honoured only in ACTIVE
- `cmd_deactivate`  in  1  pulse; start deactivation; honoured in PWR_UP, CLK_ON, ATR_WAIT, ACTIVE
- `rx_stb`  in  1  character received strobe from core
- `cfg_t_pwr`  in  W  ticks minus 1 from VCC on to CLK on
- `cfg_t_rst`  in  W  ticks minus 1 of RST low with CLK running
- `cfg_t_atr`  in  W  ticks minus 1 allowed from RST release to first ATR character
- `cfg_t_off`  in  W  ticks minus 1 between deactivation steps
- `card_vcc_en`  out  1  card supply enable
- `card_clk_en`  out  1  card clock enable
- `card_rst_n`  out  1  card RST line level
- `io_ena`  out  1  drives core `cfg_rx_ena`/`cfg_tx_ena`
- `state`  out  3  current state encoding
- `busy`  out  1  state is neither OFF nor ACTIVE
- `active`  out  1  state is ACTIVE
- `evt_atr`  out  1  one-cycle pulse when the first ATR character is accepted
- `atr_timeout`  out  1  sticky; set on ATR window expiry; cleared on ATR_WAIT entry

## Operation
- States, with their encodings: OFF=0, PWR_UP=1, CLK_ON=2, ATR_WAIT=3, ACTIVE=4, DEACT_RST=5, DEACT_CLK=6, DEACT_PWR=7.
- Dwell counter `cnt` (W bits):
  - On state entry it loads that state's config value.
  - On each `card_tick`, the state exits if `cnt==0`; otherwise `cnt` decrements.
  - Dwell is therefore cfg+1 ticks. Config values are sampled only at entry.
- OFF -> PWR_UP on `cmd_activate`: `card_vcc_en`=1; load `cfg_t_pwr`.
- PWR_UP expiry -> CLK_ON: `card_clk_en`=1, `io_ena`=1, `card_rst_n`=0; load `cfg_t_rst`.
- CLK_ON expiry -> ATR_WAIT: `card_rst_n`=1; load `cfg_t_atr`; `atr_timeout` cleared.
- ATR_WAIT:
  - `rx_stb` -> ACTIVE, with `evt_atr` pulsed.
  - Expiry -> DEACT_RST, with `atr_timeout` set.
- ACTIVE: `cmd_warm` -> CLK_ON (`card_rst_n`=0, load `cfg_t_rst`); VCC/CLK/`io_ena` unchanged.
- Deactivation:
  - `cmd_deactivate` (legal states) -> DEACT_RST: `card_rst_n`=0, `io_ena`=0; load `cfg_t_off`.
  - DEACT_RST expiry -> DEACT_CLK: `card_clk_en`=0; load `cfg_t_off`.
  - DEACT_CLK expiry -> DEACT_PWR: `card_vcc_en`=0; load `cfg_t_off`.
  - DEACT_PWR expiry -> OFF.
- Ignored inputs:
  - `rx_stb` outside ATR_WAIT.
  - `cmd_activate` outside OFF.
  - `cmd_warm` outside ACTIVE.
  - `cmd_deactivate` in OFF and DEACT_*. Deactivation is not restartable.
- Same-cycle priority: `cmd_deactivate` > `rx_stb` > ATR expiry > `cmd_warm`.
  - If `cmd_deactivate` and `rx_stb` coincide in ATR_WAIT: go to DEACT_RST, no `evt_atr`, `atr_timeout` unchanged.
  - If `rx_stb` coincides with the expiring tick: ACTIVE wins and `atr_timeout` stays 0.

## Timing
- All outputs are registered. An event sampled in cycle n is visible in `state`/pins in cycle n+1.
- `evt_atr` is high for exactly cycle n+1.
- Pin changes coincide with the state change. No pin glitches on other cycles.
- Reset values (asynchronous, immediate on `rst_n`=0 at any point, including mid-sequence):
  - `state`=OFF, `cnt`=0.
  - `card_vcc_en`=0, `card_clk_en`=0, `card_rst_n`=0, `io_ena`=0.
  - `busy`=0, `active`=0, `evt_atr`=0, `atr_timeout`=0.
- Pin ordering invariants, never violated in any state:
  - `card_clk_en` implies `card_vcc_en`.
  - `card_rst_n` implies `card_clk_en`.
  - `io_ena` implies `card_vcc_en`.

## Test plan
Defaults for all scenarios: `card_tick` every 4 clk, `cfg_t_pwr`=3, `cfg_t_rst`=9, `cfg_t_atr`=19, `cfg_t_off`=1.
- Cold activation: pulse `cmd_activate`, then `rx_stb` on the 5th tick in ATR_WAIT.
  - `card_vcc_en` rises next cycle.
  - `card_clk_en`/`io_ena` rise after 4 ticks.
  - `card_rst_n` rises 10 ticks later.
  - ACTIVE and a 1-cycle `evt_atr` one cycle after `rx_stb`.
- ATR timeout: activate with no `rx_stb`.
  - After 20 ticks in ATR_WAIT: `atr_timeout`=1 and `card_rst_n`=0.
  - 2 ticks later `card_clk_en`=0; 2 more, `card_vcc_en`=0; 2 more, OFF. `atr_timeout` stays 1.
- Warm reset: `cmd_warm` in ACTIVE.
  - `card_rst_n`=0 for 10 ticks with VCC/CLK held.
  - Then ATR_WAIT with `atr_timeout` cleared. Then `rx_stb` returns to ACTIVE.
- Collisions:
  - `cmd_deactivate` in PWR_UP -> DEACT_RST next cycle, `card_clk_en` never asserted.
  - `cmd_deactivate`+`rx_stb` same cycle in ATR_WAIT -> DEACT_RST, no `evt_atr`.
  - `cmd_activate` during DEACT_CLK ignored.
- Async reset: assert `rst_n` mid-ACTIVE between clk edges -> all outputs reach reset values immediately. After release, the block stays OFF until `cmd_activate`.
- Zero config: all cfg=0 -> every timed state dwells exactly 1 tick. The pin invariants are checked by assertion in every scenario.
